// File: rtl/qsys_led_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, per-key debounce counter,
// polarity normalisation (1 = pressed) and registered press/release strobes.
module qsys_led_key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] IDLE =
    (KEY_ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  logic [NUM_KEYS-1:0] sync1_p0;
  logic [NUM_KEYS-1:0] sync2_p1;
  logic [NUM_KEYS-1:0] stable_p2;
  logic [NUM_KEYS-1:0] press_p2;
  logic [NUM_KEYS-1:0] release_p2;
  logic [CNT_W-1:0]    cnt_p2 [NUM_KEYS];

  // Stage p0/p1: synchronizer, reset to the idle raw level so no edge follows reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_p0 <= IDLE;
      sync2_p1 <= IDLE;
    end else begin
      sync1_p0 <= key_in;
      sync2_p1 <= sync1_p0;
    end
  end

  // Stage p2: debounce; strobes fire on the same edge the stable level updates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_p2  <= IDLE;
      press_p2   <= '0;
      release_p2 <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      press_p2   <= '0;
      release_p2 <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2_p1[i] == stable_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_MAX) begin
          stable_p2[i]  <= sync2_p1[i];
          cnt_p2[i]     <= '0;
          press_p2[i]   <= (sync2_p1[i] != IDLE[i]);
          release_p2[i] <= (sync2_p1[i] == IDLE[i]);
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  assign key_out       = stable_p2 ^ IDLE;
  assign press_pulse   = press_p2;
  assign release_pulse = release_p2;

endmodule

// File: tb/tb_qsys_led_key_debounce.sv
// Bench for qsys_led_key_debounce: directed scenarios plus random bouncing,
// scored against a sliding-window reference model through an event queue.
module tb_qsys_led_key_debounce;

  localparam int NK = 4;
  localparam int D  = 8;
  localparam logic [NK-1:0] IDLE = 4'hF;

  logic          clk;
  logic          reset_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_out;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  qsys_led_key_debounce #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in),
    .key_out(key_out), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
  } ev_t;
  ev_t evq[$];

  // Reference model: a key's accepted level flips when the last D synchronized
  // samples all disagree with it; the window restarts after every flip or reset.
  int            cyc = 0;
  logic [NK-1:0] m_s1 = IDLE;
  logic [NK-1:0] m_s2 = IDLE;
  logic [NK-1:0] m_pressed = '0;
  bit            hist [NK][$];

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_s1 = IDLE;
        m_s2 = IDLE;
        m_pressed = '0;
        for (int k = 0; k < NK; k++) hist[k].delete();
      end else begin
        logic [NK-1:0] use_v;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        cyc++;
        use_v = m_s2 ^ IDLE;
        m_s2  = m_s1;
        m_s1  = key_in;
        pr = '0;
        rl = '0;
        for (int k = 0; k < NK; k++) begin
          hist[k].push_back(use_v[k]);
          if (hist[k].size() > D) void'(hist[k].pop_front());
          if (hist[k].size() == D) begin
            bit all_diff;
            all_diff = 1'b1;
            foreach (hist[k][j]) if (hist[k][j] == m_pressed[k]) all_diff = 1'b0;
            if (all_diff) begin
              m_pressed[k] = ~m_pressed[k];
              if (m_pressed[k]) pr[k] = 1'b1; else rl[k] = 1'b1;
              hist[k].delete();
            end
          end
        end
        if ((pr | rl) != '0) evq.push_back('{cyc, pr, rl});
      end
    end
  end

  // Monitor: level compare every cycle, strobe events popped from the queue
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("key_out_level", 32'(key_out), 32'(m_pressed));
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missed_strobe: expected press %0h release %0h at cycle %0d, but no strobe occurred",
                   evq[0].pr, evq[0].rl, evq[0].cyc);
          void'(evq.pop_front());
        end
        if ((press_pulse | release_pulse) != '0 || (evq.size() > 0 && evq[0].cyc == cyc)) begin
          if (evq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got press %0h release %0h at cycle %0d, none expected",
                     press_pulse, release_pulse, cyc);
          end else begin
            ev_t e;
            e = evq.pop_front();
            check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            check("press_pulse", 32'(press_pulse), 32'(e.pr));
            check("release_pulse", 32'(release_pulse), 32'(e.rl));
          end
        end
      end else begin
        check("reset_outputs", {20'd0, key_out, press_pulse, release_pulse}, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Counts edges (starting at 1) until the selected strobe of key k appears
  task automatic wait_pulse(input int k, input bit rel, output int n, output logic [NK-1:0] seen);
    n = -1;
    seen = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rel ? release_pulse[k] : press_pulse[k]) begin
        n = i;
        seen = rel ? release_pulse : press_pulse;
        break;
      end
    end
    #1;
  endtask

  initial begin
    int n;
    logic [NK-1:0] seen;
    int hold [NK];

    reset_n = 1'b0;
    key_in  = IDLE;
    step(3);
    reset_n = 1'b1;
    step(100);
    check("idle_after_reset", 32'(key_out), 32'h0);

    key_in = 4'hE;
    wait_pulse(0, 1'b0, n, seen);
    check("clean_press_latency", 32'(n), 32'd10);
    check("clean_press_vector", 32'(seen), 32'h1);
    step(1);
    check("clean_press_one_cycle", 32'(press_pulse), 32'h0);
    key_in = IDLE;
    step(20);

    for (int c = 0; c < 42; c++) begin
      key_in[1] = ((c / 3) % 2) != 0;
      step(1);
    end
    key_in[1] = 1'b0;
    wait_pulse(1, 1'b0, n, seen);
    check("bounce_press_latency", 32'(n), 32'd10);
    step(20);
    check("bounce_settled", 32'(key_out), 32'h2);
    key_in = IDLE;
    step(20);

    key_in[2] = 1'b0;
    step(7);
    key_in[2] = 1'b1;
    step(20);
    check("glitch7_rejected", 32'(key_out), 32'h0);
    key_in[2] = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    key_in[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch8_accepted", 32'(key_out), 32'h4);
    check("glitch8_press", 32'(press_pulse), 32'h4);
    step(20);
    check("glitch8_released", 32'(key_out), 32'h0);

    key_in = 4'h0;
    wait_pulse(0, 1'b0, n, seen);
    check("simul_press_latency", 32'(n), 32'd10);
    check("simul_press_vector", 32'(seen), 32'hF);
    check("simul_key_out", 32'(key_out), 32'hF);
    step(3);
    key_in = IDLE;
    wait_pulse(0, 1'b1, n, seen);
    check("simul_release_latency", 32'(n), 32'd10);
    check("simul_release_vector", 32'(seen), 32'hF);
    step(1);
    check("simul_release_one_cycle", 32'(release_pulse), 32'h0);
    step(10);

    key_in = 4'hE;
    step(14);
    key_in = 4'h6;
    step(7);
    reset_n = 1'b0;
    #1;
    check("async_reset_key_out", 32'(key_out), 32'h0);
    check("async_reset_strobes", 32'({press_pulse, release_pulse}), 32'h0);
    step(2);
    reset_n = 1'b1;
    wait_pulse(3, 1'b0, n, seen);
    check("post_reset_press_latency", 32'(n), 32'd10);
    check("post_reset_press_vector", 32'(seen), 32'h9);
    key_in = IDLE;
    step(20);

    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          key_in[k] = 1'($urandom_range(0, 1));
          hold[k] = int'($urandom_range(1, 14));
        end
        hold[k]--;
      end
      step(1);
    end

    key_in = IDLE;
    step(30);
    check("final_key_out", 32'(key_out), 32'h0);
    check("pending_events", 32'(evq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
